// File: rtl/id_issue_buf.sv
// Instruction queue between IF and ID with a per-register pending-writer scoreboard.
// Optional ID_BYPASS_EN: an empty queue forwards in_* straight to out_* (0-cycle latency).
module id_issue_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_addr,
    input  logic            flush,
    output logic            stallreq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [PW:0]      count_q;
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic            bypass, head_valid;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_inst;
    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            rs1_use, rs2_use, rd_write, long_lat;
    logic            rs1_busy, rs2_busy, sat, hazard;
    logic            fire, take, deq, enq, inc;

`ifdef ID_BYPASS_EN
    assign bypass = in_valid && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        head_valid = (count_q != '0) || bypass;
        head_pc    = '0;
        head_inst  = '0;
        if (count_q != '0) begin
            head_pc   = pc_mem[rd_ptr_q];
            head_inst = inst_mem[rd_ptr_q];
        end else if (bypass) begin
            head_pc   = in_pc;
            head_inst = in_inst;
        end
    end

    assign opcode = head_inst[6:0];
    assign rs1    = head_inst[19:15];
    assign rs2    = head_inst[24:20];
    assign rd     = head_inst[11:7];

    always_comb begin
        rs1_use  = 1'b0;
        rs2_use  = 1'b0;
        rd_write = 1'b0;
        long_lat = 1'b0;
        case (opcode)
            OpImm:           begin rs1_use = 1'b1; rd_write = 1'b1; end
            OpReg:           begin
                rs1_use  = 1'b1;
                rs2_use  = 1'b1;
                rd_write = 1'b1;
                long_lat = (head_inst[31:25] == 7'b0000001);
            end
            OpLui, OpAuipc,
            OpJal:           rd_write = 1'b1;
            OpJalr:          begin rs1_use = 1'b1; rd_write = 1'b1; end
            OpBranch,
            OpStore:         begin rs1_use = 1'b1; rs2_use = 1'b1; end
            OpLoad:          begin rs1_use = 1'b1; rd_write = 1'b1; long_lat = 1'b1; end
            default:         ;
        endcase
    end

    // A writeback this cycle that retires the last pending writer frees the source now.
    always_comb begin
        rs1_busy = (rs1 != '0) && (cnt_q[rs1] != '0) &&
                   !(wb_valid && (wb_addr == rs1) && (cnt_q[rs1] == CNT_ONE));
        rs2_busy = (rs2 != '0) && (cnt_q[rs2] != '0) &&
                   !(wb_valid && (wb_addr == rs2) && (cnt_q[rs2] == CNT_ONE));
        sat      = long_lat && rd_write && (rd != '0) && (cnt_q[rd] == CNT_MAX);
        hazard   = (rs1_use && rs1_busy) || (rs2_use && rs2_busy) || sat;
    end

    assign in_ready  = (count_q < (PW+1)'(DEPTH));
    assign out_valid = head_valid && !hazard;
    assign stallreq  = head_valid && hazard;
    assign out_pc    = head_pc;
    assign out_inst  = head_inst;
    assign out_rs1   = rs1;
    assign out_rs2   = rs2;
    assign out_rd    = rd;

    assign fire = out_valid && out_ready;
    assign take = fire && !flush;
    assign deq  = take && !bypass;
    assign enq  = in_valid && in_ready && !flush && !(bypass && fire);
    assign inc  = take && long_lat && rd_write && (rd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]   <= in_pc;
            inst_mem[wr_ptr_q] <= in_inst;
        end
    end

    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            logic hit_inc, hit_dec;
            hit_inc  = inc && (rd == 5'(i));
            hit_dec  = wb_valid && (wb_addr == 5'(i));
            cnt_d[i] = cnt_q[i];
            if (hit_inc && !hit_dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (hit_dec && !hit_inc && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule
